stream_mux_arb: RTL and testbench

STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

---
 rtl/stream_mux_arb.sv | 152 +++++++++++++++
 tb/tb_stream_mux_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// Round-robin stream multiplexer with a single registered output slot.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until in_last.
module stream_mux_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int MSEL_WIDTH = 2,
  parameter int NO_CHANNEL = 2**MSEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data [NO_CHANNEL],
  input  logic [NO_CHANNEL-1:0] in_valid,
  input  logic [NO_CHANNEL-1:0] in_last,
  output logic [NO_CHANNEL-1:0] in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [MSEL_WIDTH-1:0] out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [MSEL_WIDTH-1:0] LAST_CH = MSEL_WIDTH'(NO_CHANNEL - 1);

  logic [MSEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [MSEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;

  logic [MSEL_WIDTH-1:0] arb_idx, grant_idx, grant_inc;
  logic                  arb_found, grant_found, grant_last;
  logic                  load_en, accept, rr_adv;

  // First pass looks at channels at or above rr_ptr; if none is valid, the
  // lowest valid channel is necessarily below rr_ptr, which is the wrap case.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NO_CHANNEL; i++) begin
      if (!arb_found && in_valid[i] && (MSEL_WIDTH'(i) >= rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = MSEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < NO_CHANNEL; i++) begin
      if (!arb_found && in_valid[i]) begin
        arb_found = 1'b1;
        arb_idx   = MSEL_WIDTH'(i);
      end
    end
  end

  assign load_en    = ~out_valid_q | out_ready;
  assign accept     = load_en & grant_found;
  assign grant_last = in_last[grant_idx];
  assign grant_inc  = (grant_idx == LAST_CH) ? '0 : grant_idx + MSEL_WIDTH'(1);

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {ARB, LOCK} state_t;

  state_t                state_q, state_d;
  logic [MSEL_WIDTH-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_adv      = 1'b0;
    grant_idx   = arb_idx;
    grant_found = arb_found;
    case (state_q)
      ARB: begin
        if (accept) begin
          if (grant_last) begin
            rr_adv = 1'b1;
          end else begin
            state_d   = LOCK;
            lock_ch_d = arb_idx;
          end
        end
      end
      LOCK: begin
        // Other channels are invisible here; an idle locked channel just stalls.
        grant_idx   = lock_ch_q;
        grant_found = in_valid[lock_ch_q];
        if (accept && grant_last) begin
          state_d = ARB;
          rr_adv  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  always_comb begin
    grant_idx   = arb_idx;
    grant_found = arb_found;
    rr_adv      = accept;
  end
`endif

  always_comb begin
    rr_ptr_d    = rr_adv ? grant_inc : rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = in_data[grant_idx];
      out_last_d  = grant_last;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  // rst_n gate keeps every in_ready low for the whole reset interval.
  for (genvar gi = 0; gi < NO_CHANNEL; gi++) begin : g_ready
    assign in_ready[gi] = rst_n & accept & (grant_idx == MSEL_WIDTH'(gi));
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: a 4-channel instance for the main
// directed scenarios and a 3-channel instance for the non-power-of-two wrap.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0] d4 [4];
  logic [3:0] v4, l4, r4;
  logic [7:0] od4;
  logic       ol4, ov4, ordy4;
  logic [1:0] os4;

  logic [7:0] d3 [3];
  logic [2:0] v3, l3, r3;
  logic [7:0] od3;
  logic       ol3, ov3, ordy3;
  logic [1:0] os3;

  stream_mux_arb #(.DATA_WIDTH(8), .MSEL_WIDTH(2), .NO_CHANNEL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_last(l4),
    .in_ready(r4), .out_data(od4), .out_last(ol4), .out_sel(os4),
    .out_valid(ov4), .out_ready(ordy4)
  );

  stream_mux_arb #(.DATA_WIDTH(8), .MSEL_WIDTH(2), .NO_CHANNEL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_last(l3),
    .in_ready(r3), .out_data(od3), .out_last(ol3), .out_sel(os3),
    .out_valid(ov3), .out_ready(ordy3)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q4[$];
  beat_t q3[$];
  beat_t e4, e3;
  int checks = 0;
  int errors = 0;
  int pops4  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] s, input logic [7:0] d, input logic l);
    beat_t b;
    b.sel  = s;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the next expected beat whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (rst_n && ov4 && ordy4) begin
      pops4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4_unexpected_beat actual sel=%0d data=%h last=%0b required none", os4, od4, ol4);
      end else begin
        e4 = q4.pop_front();
        $display("dut4 beat sel=%0d data=%h last=%0b (exp sel=%0d data=%h last=%0b)",
                 os4, od4, ol4, e4.sel, e4.data, e4.last);
        chk("dut4_beat", {21'b0, os4, od4, ol4}, {21'b0, e4});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov3) begin
      chk("dut3_sel_range", {31'b0, (os3 < 2'd3)}, 32'd1);
    end
    if (rst_n && ov3 && ordy3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3_unexpected_beat actual sel=%0d data=%h required none", os3, od3);
      end else begin
        e3 = q3.pop_front();
        $display("dut3 beat sel=%0d data=%h last=%0b (exp sel=%0d data=%h last=%0b)",
                 os3, od3, ol3, e3.sel, e3.data, e3.last);
        chk("dut3_beat", {21'b0, os3, od3, ol3}, {21'b0, e3});
      end
    end
  end

  initial begin
    int start_pops;
    int b1;
    logic a1;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) d4[i] = 8'h00;
    for (int i = 0; i < 3; i++) d3[i] = 8'h00;
    v4 = 4'hF; l4 = 4'h0; ordy4 = 1'b1;
    v3 = 3'h0; l3 = 3'h0; ordy3 = 1'b1;

    // Reset state, with all channels requesting to prove in_ready is held low.
    #2;
    chk("rst_out_valid", {31'b0, ov4}, 32'd0);
    chk("rst_out_data",  {24'b0, od4}, 32'd0);
    chk("rst_out_sel",   {30'b0, os4}, 32'd0);
    chk("rst_out_last",  {31'b0, ol4}, 32'd0);
    chk("rst_in_ready",  {28'b0, r4},  32'd0);
    repeat (2) step();
    chk("rst_in_ready_clocked", {28'b0, r4}, 32'd0);
    v4 = 4'h0;
    rst_n = 1'b1;
    step();

    // All valid, single-beat packets: 0,1,2,3,0 back to back.
    for (int i = 0; i < 4; i++) d4[i] = 8'hC0 + 8'(i);
    l4 = 4'hF;
    q4.push_back(mk(2'd0, 8'hC0, 1'b1));
    q4.push_back(mk(2'd1, 8'hC1, 1'b1));
    q4.push_back(mk(2'd2, 8'hC2, 1'b1));
    q4.push_back(mk(2'd3, 8'hC3, 1'b1));
    q4.push_back(mk(2'd0, 8'hC0, 1'b1));
    start_pops = pops4;
    v4 = 4'hF;
    repeat (5) step();
    v4 = 4'h0;
    step();
    chk("rr_no_bubble_beats", 32'(pops4 - start_pops), 32'd5);
    chk("rr_drained", {31'b0, ov4}, 32'd0);

    // Only ch2 valid while downstream stalls for three cycles.
    d4[2] = 8'hA5;
    l4 = 4'b0100;
    v4 = 4'b0100;
    ordy4 = 1'b0;
    q4.push_back(mk(2'd2, 8'hA5, 1'b1));
    step();
    for (int k = 0; k < 3; k++) begin
      $display("stall cycle %0d valid=%0b data=%h sel=%0d in_ready=%b", k, ov4, od4, os4, r4);
      chk("stall_valid",    {31'b0, ov4}, 32'd1);
      chk("stall_data",     {24'b0, od4}, 32'hA5);
      chk("stall_sel",      {30'b0, os4}, 32'd2);
      chk("stall_in_ready", {28'b0, r4},  32'd0);
      step();
    end
    v4 = 4'h0;
    ordy4 = 1'b1;
    step();
    chk("stall_drained", {31'b0, ov4}, 32'd0);

    // rr_ptr is now 3: ch3 wins over ch0, then the pointer wraps to ch0.
    d4[3] = 8'hD3;
    d4[0] = 8'hD0;
    l4 = 4'hF;
    v4 = 4'b1001;
    q4.push_back(mk(2'd3, 8'hD3, 1'b1));
    q4.push_back(mk(2'd0, 8'hD0, 1'b1));
    repeat (2) step();
    v4 = 4'h0;
    repeat (2) step();

    // ch1 sends a 3-beat packet while ch0 keeps offering single-beat packets.
    d4[0] = 8'h01;
    d4[1] = 8'h11;
    l4 = 4'b0001;
    v4 = 4'b0011;
`ifdef STREAM_MUX_PKT_LOCK_EN
    q4.push_back(mk(2'd1, 8'h11, 1'b0));
    q4.push_back(mk(2'd1, 8'h12, 1'b0));
    q4.push_back(mk(2'd1, 8'h13, 1'b1));
    q4.push_back(mk(2'd0, 8'h01, 1'b1));
`else
    q4.push_back(mk(2'd1, 8'h11, 1'b0));
    q4.push_back(mk(2'd0, 8'h01, 1'b1));
    q4.push_back(mk(2'd1, 8'h12, 1'b0));
    q4.push_back(mk(2'd0, 8'h01, 1'b1));
    q4.push_back(mk(2'd1, 8'h13, 1'b1));
    q4.push_back(mk(2'd0, 8'h01, 1'b1));
`endif
    b1 = 0;
    for (int cyc = 0; cyc < 20 && b1 < 3; cyc++) begin
      @(negedge clk);
      a1 = r4[1] & v4[1];
      step();
      if (a1) begin
        b1++;
        d4[1] = 8'h11 + 8'(b1);
        l4[1] = (b1 == 2);
        if (b1 == 3) v4[1] = 1'b0;
      end
    end
    chk("pkt_ch1_beats_sent", 32'(b1), 32'd3);
    step();
    v4 = 4'h0;
    repeat (2) step();

    // Reset in the middle of a ch2 packet with the output slot full.
    d4[2] = 8'h22;
    l4 = 4'h0;
    v4 = 4'b0100;
    ordy4 = 1'b0;
    step();
    chk("midpkt_slot_full", {31'b0, ov4}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midpkt_rst_valid",    {31'b0, ov4}, 32'd0);
    chk("midpkt_rst_sel",      {30'b0, os4}, 32'd0);
    chk("midpkt_rst_in_ready", {28'b0, r4},  32'd0);
    d4[0] = 8'h05;
    d4[2] = 8'h23;
    l4 = 4'hF;
    v4 = 4'b0101;
    ordy4 = 1'b1;
    step();
    rst_n = 1'b1;
    q4.push_back(mk(2'd0, 8'h05, 1'b1));
    q4.push_back(mk(2'd2, 8'h23, 1'b1));
    repeat (2) step();
    v4 = 4'h0;
    step();

    // Three-channel instance: 0,1,2,0 and never index 3.
    for (int i = 0; i < 3; i++) d3[i] = 8'hE0 + 8'(i);
    l3 = 3'h7;
    q3.push_back(mk(2'd0, 8'hE0, 1'b1));
    q3.push_back(mk(2'd1, 8'hE1, 1'b1));
    q3.push_back(mk(2'd2, 8'hE2, 1'b1));
    q3.push_back(mk(2'd0, 8'hE0, 1'b1));
    v3 = 3'h7;
    repeat (4) step();
    v3 = 3'h0;
    step();

    for (int w = 0; w < 20 && (q4.size() != 0 || q3.size() != 0); w++) step();
    chk("dut4_queue_empty", 32'(q4.size()), 32'd0);
    chk("dut3_queue_empty", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
